// File: rtl/vga_scanout.sv
// vga_scanout: fetches framebuffer bytes over a req/ack port into a prefetch FIFO and shifts them out as pixels
module vga_scanout #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_START    = 64,
    parameter int H_ACTIVE   = 512,
    parameter int V_START    = 91,
    parameter int V_ACTIVE   = 342,
    parameter int BPP        = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEAD       = 32,
    parameter int ADDR_W     = 15
) (
    input  logic              pixClock,
    input  logic              reset,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic [ADDR_W-1:0] vramBase,
    input  logic              invert,
    output logic              vramReq,
    output logic [ADDR_W-1:0] vramAddr,
    input  logic              vramAck,
    input  logic [7:0]        vramData,
    output logic [BPP-1:0]    pixOut,
    output logic              pixValid,
    output logic              underrun,
    input  logic              underrunClr
);
    localparam int PPB    = 8 / BPP;
    localparam int BPL    = H_ACTIVE * BPP / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FW     = $clog2(BPL + 1);
    localparam int H_END  = (H_START + H_ACTIVE < H_TOTAL) ? H_START + H_ACTIVE : H_TOTAL;
    localparam int V_END  = (V_START + V_ACTIVE < V_TOTAL) ? V_START + V_ACTIVE : V_TOTAL;
    localparam int H_OPEN = (H_START > LEAD) ? H_START - LEAD : 0;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, line_addr_q, line_addr_d;
    logic [FW-1:0]     fetch_idx_q, fetch_idx_d;
    logic              discard_q, discard_d;
    logic [1:0]        drop_q, drop_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d, src;
    logic              blank_q, blank_d;
    logic [BPP-1:0]    pix_q, pix_d;
    logic              valid_q, valid_d, underrun_q, underrun_d;
    logic h_act, v_act, frame_start, line_end, fetch_open, ack, push, start_req, pop, pop_ok, drop_inc, drop_dec;

    assign h_act       = hCount >= 10'(H_START) && hCount < 10'(H_END);
    assign v_act       = vCount >= 10'(V_START) && vCount < 10'(V_END);
    assign frame_start = hCount == 10'd0 && vCount == 10'd0;
    assign line_end    = v_act && hCount == 10'(H_END);
    assign fetch_open  = v_act && hCount >= 10'(H_OPEN) && hCount < 10'(H_END);
    assign ack         = state_q == REQ && vramAck;
    // Stale (discarded) or skipped-slot data never lands; a flush in the same cycle also wins.
    assign push        = ack && !discard_q && drop_q == 2'd0 && !line_end;
    assign start_req   = state_q == IDLE && fetch_open && fetch_idx_q < FW'(BPL) && cnt_q < (AW+1)'(FIFO_DEPTH);
    assign pop         = v_act && h_act && ((hCount - 10'(H_START)) & 10'(PPB - 1)) == 10'd0;
    assign pop_ok      = pop && cnt_q != '0;
    // Each empty slot owes one byte that must be skipped to keep later slots address-aligned.
    assign drop_inc    = pop && !pop_ok && drop_q != 2'd3;
    assign drop_dec    = ack && !discard_q && drop_q != 2'd0;
    assign src         = pop ? (pop_ok ? mem_q[rd_q] : 8'd0) : shift_q;

    assign vramReq  = state_q == REQ;
    assign vramAddr = addr_q;
    assign pixOut   = pix_q;
    assign pixValid = valid_q;
    assign underrun = underrun_q;

    // Next-state for fetch FSM, FIFO pointers, shifter and status.
    always_comb begin
        state_d     = start_req ? REQ : (ack ? IDLE : state_q);
        addr_d      = start_req ? line_addr_q + ADDR_W'(fetch_idx_q) : addr_q;
        discard_d   = line_end ? (state_q == REQ && !vramAck) : (ack ? 1'b0 : discard_q);
        fetch_idx_d = line_end ? '0 : ((ack && !discard_q) ? fetch_idx_q + FW'(1) : fetch_idx_q);
        drop_d      = line_end ? 2'd0 : drop_q + {1'b0, drop_inc} - {1'b0, drop_dec};
        line_addr_d = frame_start ? vramBase : (line_end ? line_addr_q + ADDR_W'(BPL) : line_addr_q);
        cnt_d       = line_end ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop_ok);
        wr_d        = line_end ? '0 : wr_q + AW'(push);
        rd_d        = line_end ? '0 : rd_q + AW'(pop_ok);
        shift_d     = src << BPP;
        blank_d     = pop ? !pop_ok : blank_q;
        pix_d       = (h_act && v_act && !blank_d) ? src[7 -: BPP] ^ {BPP{invert}} : '0;
        valid_d     = h_act && v_act;
        underrun_d  = (pop && !pop_ok) ? 1'b1 : (underrunClr ? 1'b0 : underrun_q);
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge pixClock) begin
        if (push) mem_q[wr_q] <= vramData;
    end

    // State registers with synchronous reset.
    always_ff @(posedge pixClock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            line_addr_q <= '0;
            fetch_idx_q <= '0;
            discard_q   <= 1'b0;
            drop_q      <= 2'd0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            shift_q     <= 8'd0;
            blank_q     <= 1'b0;
            pix_q       <= '0;
            valid_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_addr_q <= line_addr_d;
            fetch_idx_q <= fetch_idx_d;
            discard_q   <= discard_d;
            drop_q      <= drop_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            blank_q     <= blank_d;
            pix_q       <= pix_d;
            valid_q     <= valid_d;
            underrun_q  <= underrun_d;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of fetch addressing, pixel shifting, underrun and reset recovery
module tb_vga_scanout;
    localparam int HT = 120;
    localparam int VT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h, v;
    logic [14:0] base;
    logic        inv, clr, ack_en;
    logic        req1, pv1, ur1;
    logic [14:0] addr1;
    logic [0:0]  pix1;
    logic        req2, pv2, ur2;
    logic [14:0] addr2;
    logic [1:0]  pix2;
    logic [7:0]  data1;
    logic [7:0]  b;
    int          n_chk = 0;
    int          n_fail = 0;

    assign data1 = addr1[7:0];

    always #5 clk = ~clk;

    vga_scanout #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(40), .H_ACTIVE(64), .V_START(2), .V_ACTIVE(4),
                  .BPP(1), .FIFO_DEPTH(4), .LEAD(32), .ADDR_W(15)) dut1 (
        .pixClock(clk), .reset(rst), .hCount(h), .vCount(v), .vramBase(base), .invert(inv),
        .vramReq(req1), .vramAddr(addr1), .vramAck(ack_en), .vramData(data1),
        .pixOut(pix1), .pixValid(pv1), .underrun(ur1), .underrunClr(clr));

    vga_scanout #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(40), .H_ACTIVE(64), .V_START(2), .V_ACTIVE(4),
                  .BPP(2), .FIFO_DEPTH(4), .LEAD(32), .ADDR_W(15)) dut2 (
        .pixClock(clk), .reset(rst), .hCount(h), .vCount(v), .vramBase(base), .invert(inv),
        .vramReq(req2), .vramAddr(addr2), .vramAck(1'b1), .vramData(8'hE4),
        .pixOut(pix2), .pixValid(pv2), .underrun(ur2), .underrunClr(1'b0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (h == 10'(HT - 1)) begin
            h = 10'd0;
            v = (v == 10'(VT - 1)) ? 10'd0 : v + 10'd1;
        end else h = h + 10'd1;
    endtask

    task automatic run_until(input int th, input int tv);
        int n;
        n = 0;
        while (!(h == 10'(th) && v == 10'(tv)) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            n_chk++;
            n_fail++;
            $error("FAIL timeout: observed h=%0d v=%0d expected h=%0d v=%0d", h, v, th, tv);
        end
    endtask

    task automatic get_byte(output logic [7:0] r);
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            r = {r[6:0], pix1};
        end
    endtask

    initial begin
        rst = 1'b1; h = 10'd0; v = 10'd0; base = 15'd0; inv = 1'b0; clr = 1'b0; ack_en = 1'b1;
        tick(); tick(); tick();
        chk("rst_req", req1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_pix", pix1, 0);
        chk("rst_valid", pv1, 0);
        chk("rst_underrun", ur1, 0);
        chk("rst_valid2", pv2, 0);
        rst = 1'b0; h = 10'd0; v = 10'd0;
        // First active line: bytes 0 and 1 from base 0
        run_until(40, 2);
        get_byte(b); chk("l0_byte0", b, 8'h00);
        get_byte(b); chk("l0_byte1", b, 8'h01);
        chk("l0_valid", pv1, 1);
        run_until(104, 2);
        tick();
        chk("out_valid", pv1, 0);
        chk("out_pix", pix1, 0);
        // Second line starts one BPL further on
        run_until(8, 3);
        tick();
        chk("l1_req", req1, 1);
        chk("l1_addr", addr1, 8);
        // 2bpp pixel order and inversion
        run_until(40, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bpp2_norm", pix2, 3 - i);
        end
        inv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bpp2_inv", pix2, i);
        end
        run_until(104, 3);
        tick();
        chk("bpp2_out_pix", pix2, 0);
        chk("bpp2_out_valid", pv2, 0);
        inv = 1'b0;
        run_until(0, 0);
        chk("frame1_underrun", ur1, 0);
        // Line address wrap
        base = 15'h7FF8;
        run_until(8, 2);
        tick();
        chk("wrap_l0_addr", addr1, 15'h7FF8);
        run_until(40, 2);
        get_byte(b); chk("wrap_l0_byte", b, 8'hF8);
        run_until(8, 3);
        tick();
        chk("wrap_l1_addr", addr1, 0);
        // Underrun: prefetch four bytes, then stall the arbiter
        run_until(0, 0);
        base = 15'd0;
        run_until(20, 4);
        ack_en = 1'b0;
        run_until(40, 4);
        for (int k = 0; k < 4; k++) begin
            get_byte(b);
            chk("ur_prefetch", b, 8'h10 + k);
        end
        chk("ur_before", ur1, 0);
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            b = {b[6:0], pix1};
            if (i == 3) ack_en = 1'b1;
        end
        chk("ur_slot_blank", b, 8'h00);
        chk("ur_set", ur1, 1);
        get_byte(b); chk("ur_slot5", b, 8'h15);
        get_byte(b); chk("ur_slot6", b, 8'h16);
        get_byte(b); chk("ur_slot7", b, 8'h17);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ur_clear", ur1, 0);
        // Set wins over a simultaneous clear
        run_until(0, 5);
        ack_en = 1'b0;
        run_until(40, 5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ur_set_wins", ur1, 1);
        chk("ur_blank_valid", pv1, 1);
        chk("ur_blank_pix", pix1, 0);
        // Reset while a request is stuck
        chk("stuck_req", req1, 1);
        rst = 1'b1;
        tick();
        chk("midrst_req", req1, 0);
        chk("midrst_valid", pv1, 0);
        chk("midrst_underrun", ur1, 0);
        rst = 1'b0;
        ack_en = 1'b1;
        base = 15'h00A0;
        run_until(40, 2);
        get_byte(b); chk("after_rst_byte0", b, 8'hA0);
        get_byte(b); chk("after_rst_byte1", b, 8'hA1);
        chk("after_rst_underrun", ur1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised scan-out engine for the SE-VGA video path. It sits between the VGA timing generator (hCount/vCount) and the VRAM arbiter, and fetches framebuffer bytes through a request/acknowledge handshake into a small prefetch FIFO. It then shifts those bytes out as 1-, 2- or 4-bit pixels inside a programmable active window. It tolerates variable VRAM latency while the CPU shares the bus, and it reports underruns.

## Interface
Parameters:
- H_TOTAL, 800: pixel clocks per line.
- V_TOTAL, 525: lines per frame.
- H_START, 64: first active hCount.
- H_ACTIVE, 512: active pixels per line. Must be a multiple of 8.
- V_START, 91: first active vCount.
- V_ACTIVE, 342: active lines.
- BPP, 1: bits per pixel, one of 1, 2 or 4. PPB = 8/BPP pixels per byte. BPL = H_ACTIVE*BPP/8 bytes per line.
- FIFO_DEPTH, 4: prefetch bytes. Power of 2, at least 2.
- LEAD, 32: clocks before H_START at which line fetching opens.
- ADDR_W, 15: VRAM byte address width.

Ports:
- pixClock, in, 1: pixel clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- hCount, in, 10: horizontal position from the timing generator. Range 0..H_TOTAL-1.
- vCount, in, 10: vertical position. Range 0..V_TOTAL-1.
- vramBase, in, ADDR_W: framebuffer base address. Sampled at frame start only.
- invert, in, 1: when 1, active pixels are bitwise inverted. Sampled per pixel.
- vramReq, out, 1: read request to the arbiter.
- vramAddr, out, ADDR_W: read address. Stable while vramReq=1.
- vramAck, in, 1: arbiter acknowledge. vramData is valid in the same cycle.
- vramData, in, 8: read data.
- pixOut, out, BPP: pixel value. 0 outside the active window.
- pixValid, out, 1: 1 when pixOut belongs to the active window.
- underrun, out, 1: sticky; set on any FIFO-empty pop.
- underrunClr, in, 1: clears underrun. A set in the same cycle wins.

## Operation
- Window: hAct = H_START ≤ hCount < H_START+H_ACTIVE. vAct = V_START ≤ vCount < V_START+V_ACTIVE.
- Frame start, at hCount=0 and vCount=0:
  - lineAddr ← vramBase.
- Line end, at hCount = H_START+H_ACTIVE with vAct:
  - lineAddr ← lineAddr+BPL, wrapping modulo 2^ADDR_W.
  - FIFO flushed; fetchIdx ← 0; dropCnt ← 0.
  - Any outstanding request is marked "discard". It still completes its handshake, but its data is not written.
- Fetch FSM, states IDLE → REQ → IDLE:
  - IDLE→REQ when vAct, the fetch window is open (hCount ≥ H_START-LEAD and before line end), fetchIdx < BPL, and FIFO count < FIFO_DEPTH.
  - In REQ, vramReq=1 and vramAddr = lineAddr+fetchIdx.
  - REQ→IDLE on vramAck. On the ack, data is pushed (unless discard or dropCnt>0, in which case dropCnt decrements and data is dropped) and fetchIdx increments.
  - At most one request is outstanding. Idle and reset state: vramReq=0.
- Shifter:
  - On the first pixel of each byte slot (hAct and (hCount-H_START) mod PPB = 0): pop the FIFO into the shift register.
  - Pixels are emitted MSB-first, BPP bits per clock.
  - Pop with FIFO empty: the whole slot outputs 0 with pixValid=1, underrun is set, and dropCnt increments (saturating at 3). This keeps the addresses of later slots aligned.
- Push and pop in the same cycle are both honoured, and the count is unchanged. A push into a full FIFO cannot occur, because the FSM checks the count.
- Outside vAct: no fetches, no pops, pixOut=0, pixValid=0.
- Reset values:
  - vramReq=0, vramAddr=0, pixOut=0, pixValid=0, underrun=0.
  - FIFO empty; lineAddr=0, fetchIdx=0, dropCnt=0.
  - Reset mid-request drops vramReq on the next edge. The arbiter must tolerate an abandoned request.

## Timing
- pixOut and pixValid are registered with a latency of 1 clock. The pixel for hCount=N appears after the edge that samples N. The timing generator delays sync by 1 to match.
- vramReq rises on the edge after the IDLE→REQ condition holds. The minimum fetch period is 2 clocks per byte when vramAck is held high.
- At BPP=4 (PPB=2) the FIFO must refill once every 2 clocks. Sustained display requires ack latency 0; any stall consumes FIFO margin.
- underrun sets on the edge of the failing pop and clears on the edge after underrunClr when no set is pending.

## Test plan
- BPP=1, vramAck tied 1, frame data byte k = k[7:0]:
  - At line V_START, pixels 0..7 = 0,0,0,0,0,0,0,0.
  - Pixels 8..15 = 0,0,0,0,0,0,0,1.
  - vramAddr for line 2 starts at vramBase+128. underrun stays 0.
- BPP=2, vramData=8'hE4, invert=0 → pixOut sequence 3,2,1,0. With invert=1 → 0,1,2,3. Outside the window pixOut=0 in both cases.
- vramAck withheld 40 clocks at line start, FIFO_DEPTH=4, BPP=1:
  - The first 4 slots display from the prefetch, then the 5th slot shows 0 and underrun=1.
  - The next acked byte is dropped, and later slots show bytes at their correct addresses.
- lineAddr wrap: vramBase = 2^15-64, BPL=64 → line 1 fetch address = 0.
- Reset asserted while vramReq=1 → vramReq=0, pixValid=0 and FIFO empty on the next edge. The next frame displays correctly from vramBase.
- underrunClr asserted in the same cycle as a new underrun → underrun stays 1.
